// File: rtl/dca_matrix_row_drainer.sv
// -----------------------------------------------------------------------------
// dca_matrix_row_drainer
//
// Captures a full N x N matrix from a DCA matrix register in one cycle, then
// streams it out one vector per valid/ready handshake. In normal mode each
// vector is a row. In transpose mode each vector is a column. Because the
// source is snapshotted, the matrix register can be reloaded while the drain
// is still running.
//
// Ports:
//   clk               clock
//   rstnn             asynchronous active-low reset
//   start             request snapshot + drain (accepted in IDLE or DONE)
//   transpose         sampled with start; 1 = emit columns
//   abort             cancel a drain in progress (wins over a handshake)
//   all_rdata_list2d  source matrix, element (r,c) at index r*N+c, LSB first
//   busy              drain in progress
//   done              one-cycle pulse after the final handshake
//   row_valid         row_data / row_index are valid
//   row_ready         consumer accepts the current vector
//   row_data          emitted vector, element j at bits [j*BW +: BW]
//   row_index         index of the emitted vector, 0..N-1
//   row_last          row_index == N-1 while row_valid
// -----------------------------------------------------------------------------
module dca_matrix_row_drainer #(
  parameter int  MATRIX_SIZE_PARA = 8,
  parameter int  BW_TENSOR_SCALAR = 32,
  localparam int BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR,
  localparam int BW_TENSOR_MATRIX = MATRIX_SIZE_PARA * BW_TENSOR_ROW,
  localparam int BW_INDEX         = (MATRIX_SIZE_PARA > 1) ? $clog2(MATRIX_SIZE_PARA) : 1
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic                        start,
  input  logic                        transpose,
  input  logic                        abort,
  input  logic [BW_TENSOR_MATRIX-1:0] all_rdata_list2d,
  output logic                        busy,
  output logic                        done,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [BW_TENSOR_ROW-1:0]    row_data,
  output logic [BW_INDEX-1:0]         row_index,
  output logic                        row_last
);

  localparam int                N        = MATRIX_SIZE_PARA;
  localparam int                BW       = BW_TENSOR_SCALAR;
  localparam logic [BW_INDEX-1:0] LAST_IDX = BW_INDEX'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                      state;
  logic [BW_TENSOR_MATRIX-1:0] snapshot_p0;
  logic                        transpose_p0;

  // Stage p0: snapshot of the source matrix and drain mode, taken on start.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      row_valid    <= 1'b0;
      row_index    <= '0;
      snapshot_p0  <= '0;
      transpose_p0 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE behaves like IDLE for start acceptance so drains can run
        // back-to-back with a single done cycle between them.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_SEND;
            busy         <= 1'b1;
            row_valid    <= 1'b1;
            row_index    <= '0;
            snapshot_p0  <= all_rdata_list2d;
            transpose_p0 <= transpose;
          end else begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            row_valid <= 1'b0;
          end
        end
        ST_SEND: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            row_valid <= 1'b0;
            row_index <= '0;
          end else if (row_ready) begin
            if (row_index == LAST_IDX) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              row_valid <= 1'b0;
              done      <= 1'b1;
              row_index <= '0;
            end else begin
              row_index <= row_index + BW_INDEX'(1);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          row_valid <= 1'b0;
          row_index <= '0;
        end
      endcase
    end
  end

  // Vector selection straight off the snapshot: row r of the matrix in normal
  // mode, column r in transpose mode. Stable while the index is held.
  always_comb begin
    row_data = '0;
    for (int j = 0; j < N; j++) begin
      if (transpose_p0)
        row_data[j*BW +: BW] = snapshot_p0[(j*N + int'(row_index))*BW +: BW];
      else
        row_data[j*BW +: BW] = snapshot_p0[(int'(row_index)*N + j)*BW +: BW];
    end
  end

  assign row_last = row_valid && (row_index == LAST_IDX);

endmodule

// File: tb/tb_dca_matrix_row_drainer.sv
module tb_dca_matrix_row_drainer;

  localparam int N  = 4;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              rstnn = 1'b0;
  logic              start = 1'b0;
  logic              transpose = 1'b0;
  logic              abort = 1'b0;
  logic              row_ready = 1'b0;
  logic [N*N*BW-1:0] src = '0;
  logic              busy, done, row_valid, row_last;
  logic [N*BW-1:0]   row_data;
  logic [1:0]        row_index;

  int errors = 0;
  int checks = 0;

  // Reference matrix the current drain is expected to reproduce.
  logic [7:0] mref [N][N];

  dca_matrix_row_drainer #(
    .MATRIX_SIZE_PARA(N),
    .BW_TENSOR_SCALAR(BW)
  ) dut (
    .clk(clk),
    .rstnn(rstnn),
    .start(start),
    .transpose(transpose),
    .abort(abort),
    .all_rdata_list2d(src),
    .busy(busy),
    .done(done),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_data(row_data),
    .row_index(row_index),
    .row_last(row_last)
  );

  always #5 clk = ~clk;

  function automatic logic [N*N*BW-1:0] pack_ref();
    logic [N*N*BW-1:0] s;
    s = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        s[(r*N+c)*BW +: BW] = mref[r][c];
    return s;
  endfunction

  function automatic logic [N*BW-1:0] exp_vec(int idx, bit tr);
    logic [N*BW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      v[j*BW +: BW] = tr ? mref[j][idx] : mref[idx][j];
    return v;
  endfunction

  task automatic fill_fixed();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mref[r][c] = 8'(16*r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mref[r][c] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({busy, done, row_valid, row_last} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, row_valid, row_last}); end
    checks++; if (row_index !== 2'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", row_index); end
    checks++; if (row_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", row_data); end
    rstnn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] rows [4];
    rows = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
    fill_fixed();
    src = pack_ref();
    start = 1'b1; transpose = 1'b0; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++; if (row_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_valid k=%0d got=%b%b exp=11", k, row_valid, busy); end
      checks++; if (row_index !== 2'(k)) begin errors++; $display("FAIL basic_index got=%0d exp=%0d", row_index, k); end
      checks++; if (row_data !== rows[k] || row_data !== exp_vec(k, 1'b0)) begin errors++; $display("FAIL basic_data k=%0d got=%h exp=%h", k, row_data, rows[k]); end
      checks++; if (row_last !== (k == N-1)) begin errors++; $display("FAIL basic_last k=%0d got=%b exp=%b", k, row_last, (k == N-1)); end
      @(negedge clk);
    end
    checks++; if ({done, busy, row_valid} !== 3'b100) begin errors++; $display("FAIL basic_done got=%b exp=100", {done, busy, row_valid}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_transpose();
    logic [31:0] cols [4];
    cols = '{32'h30201000, 32'h31211101, 32'h32221202, 32'h33231303};
    fill_fixed();
    src = pack_ref();
    start = 1'b1; transpose = 1'b1; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; transpose = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++; if (row_valid !== 1'b1 || row_index !== 2'(k)) begin errors++; $display("FAIL tr_index k=%0d got=%b/%0d exp=1/%0d", k, row_valid, row_index, k); end
      checks++; if (row_data !== cols[k] || row_data !== exp_vec(k, 1'b1)) begin errors++; $display("FAIL tr_data k=%0d got=%h exp=%h", k, row_data, cols[k]); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tr_done got=%b exp=1", done); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit pat [4];
    int idx, hs, dn;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx = 0; hs = 0; dn = 0;
    fill_fixed();
    src = pack_ref();
    start = 1'b1; transpose = 1'b0; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && dn == 0; cyc++) begin
      if (row_valid) begin
        checks++; if (row_index !== 2'(idx) || row_data !== exp_vec(idx, 1'b0)) begin errors++; $display("FAIL bp_hold cyc=%0d got=%0d/%h exp=%0d/%h", cyc, row_index, row_data, idx, exp_vec(idx, 1'b0)); end
      end
      if (done) dn++;
      row_ready = pat[cyc % 4];
      if (row_valid && row_ready) begin hs++; idx++; end
      @(negedge clk);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (hs !== 4) begin errors++; $display("FAIL bp_handshakes got=%0d exp=4", hs); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", dn); end
    row_ready = 1'b1;
  endtask

  task automatic test_snapshot();
    int idx, dn;
    idx = 0; dn = 0;
    fill_fixed();
    src = pack_ref();
    start = 1'b1; transpose = 1'b0; row_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    src = '1;
    for (int cyc = 0; cyc < 100 && dn == 0; cyc++) begin
      start = (cyc == 1);
      transpose = (cyc == 1);
      if (row_valid) begin
        checks++; if (row_index !== 2'(idx) || row_data !== exp_vec(idx, 1'b0)) begin errors++; $display("FAIL snap_data cyc=%0d got=%0d/%h exp=%0d/%h", cyc, row_index, row_data, idx, exp_vec(idx, 1'b0)); end
      end
      if (done) dn++;
      row_ready = 1'($urandom_range(0, 1));
      if (row_valid && row_ready) idx++;
      @(negedge clk);
    end
    start = 1'b0; transpose = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (done) dn++;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL snap_restart got=%b exp=0", busy); end
      @(negedge clk);
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL snap_done_count got=%0d exp=1", dn); end
    checks++; if (idx !== 4) begin errors++; $display("FAIL snap_handshakes got=%0d exp=4", idx); end
  endtask

  task automatic test_abort();
    int seen;
    fill_random();
    src = pack_ref();
    start = 1'b1; transpose = 1'b0; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (row_index !== 2'd1 || row_valid !== 1'b1) begin errors++; $display("FAIL abort_pre got=%0d/%b exp=1/1", row_index, row_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({row_valid, busy, done} !== 3'b000 || row_index !== 2'd0) begin errors++; $display("FAIL abort_state got=%b idx=%0d exp=000 idx=0", {row_valid, busy, done}, row_index); end
    seen = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    fill_random();
    src = pack_ref();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (row_valid !== 1'b1 || row_index !== 2'd0 || row_data !== exp_vec(0, 1'b0)) begin errors++; $display("FAIL abort_restart got=%b/%0d/%h exp=1/0/%h", row_valid, row_index, row_data, exp_vec(0, 1'b0)); end
    seen = 0;
    for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL abort_redrain_done got=%0d exp=1", seen); end
  endtask

  task automatic test_back_to_back();
    int seen;
    fill_fixed();
    src = pack_ref();
    start = 1'b1; transpose = 1'b0; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (row_index !== 2'd2) begin errors++; $display("FAIL rst_pre got=%0d exp=2", row_index); end
    rstnn = 1'b0;
    #1;
    checks++; if ({busy, done, row_valid, row_last} !== 4'b0 || row_index !== 2'd0 || row_data !== '0) begin errors++; $display("FAIL rst_async got=%b idx=%0d data=%h exp=0", {busy, done, row_valid, row_last}, row_index, row_data); end
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, row_valid} !== 3'b000) begin errors++; $display("FAIL rst_after got=%b exp=000", {busy, done, row_valid}); end
    fill_random();
    src = pack_ref();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
      if (done) seen++;
      else @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL b2b_first_done got=%0d exp=1", seen); end
    fill_random();
    src = pack_ref();
    transpose = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; transpose = 1'b0;
    checks++; if (row_valid !== 1'b1 || busy !== 1'b1 || row_index !== 2'd0 || row_data !== exp_vec(0, 1'b1)) begin errors++; $display("FAIL b2b_restart got=%b%b/%0d/%h exp=11/0/%h", row_valid, busy, row_index, row_data, exp_vec(0, 1'b1)); end
    seen = 0;
    for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL b2b_second_done got=%0d exp=1", seen); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int idx, dn;
      bit tr;
      idx = 0; dn = 0;
      tr = 1'($urandom_range(0, 1));
      fill_random();
      src = pack_ref();
      start = 1'b1; transpose = tr; row_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; transpose = 1'b0;
      for (int cyc = 0; cyc < 200 && dn == 0; cyc++) begin
        src = {$urandom, $urandom, $urandom, $urandom};
        if (done) dn++;
        else begin
          checks++; if (row_valid !== 1'b1 || busy !== 1'b1 || row_index !== 2'(idx) || row_data !== exp_vec(idx, tr) || row_last !== (idx == N-1)) begin errors++; $display("FAIL rand it=%0d idx=%0d got=%b%b%b/%0d/%h exp=%h", it, idx, row_valid, busy, row_last, row_index, row_data, exp_vec(idx, tr)); end
        end
        row_ready = ($urandom_range(0, 9) < 6);
        if (row_valid && row_ready) idx++;
        @(negedge clk);
      end
      checks++; if (dn !== 1 || idx !== N) begin errors++; $display("FAIL rand_end it=%0d got=done%0d/hs%0d exp=done1/hs4", it, dn, idx); end
    end
    row_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_transpose();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
